// File: rtl/pool_l1_relu_max.sv
// -----------------------------------------------------------------------------
// pool_l1_relu_max
//
// Layer-1 pooling stage. It walks one finished first-convolution result map in
// non-overlapping 2x2 windows. For each window it computes max(0, w0..w3), which
// is ReLU fused with max-pooling. Each result is written row-major into an
// internal pooled buffer. The next layer reads that buffer through an
// independent registered read port.
//
// Ports
//   clk               in   rising-edge clock for all logic
//   reset             in   synchronous, active-high reset
//   run               in   start request, level-sampled only while idle
//   conv_result_addr  out  conv result read address, row*CONV_RESULT_WIDTH+col
//   conv_result       in   conv result word, valid one cycle after its address
//   pool_read_address in   pooled buffer read address, row*POOL_W+col
//   pool_result       out  registered pooled word for pool_read_address
//                          (0 for addresses beyond the pooled map)
//   done              out  pooling complete; held while run stays high
//
// Per-window schedule (6 cycles):
//   FETCH k=0..3 present the 4 window addresses, DRAIN takes the last word,
//   WRITE stores the accumulator and steps to the next window.
// -----------------------------------------------------------------------------
module pool_l1_relu_max #(
  parameter int DATA_WIDTH         = 16,
  parameter int FRACTION_WIDTH     = 8,
  parameter int ADDR_WIDTH         = 10,
  parameter int CONV_RESULT_WIDTH  = 24,
  parameter int CONV_RESULT_HEIGHT = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] conv_result_addr,
  input  logic [DATA_WIDTH-1:0] conv_result,
  input  logic [ADDR_WIDTH-1:0] pool_read_address,
  output logic [DATA_WIDTH-1:0] pool_result,
  output logic                  done
);

  // Odd map dimensions drop the trailing column/row (floor division).
  localparam int POOL_W     = CONV_RESULT_WIDTH / 2;
  localparam int POOL_H     = CONV_RESULT_HEIGHT / 2;
  localparam int POOL_DEPTH = POOL_W * POOL_H;
  localparam int PIDX_W     = (POOL_DEPTH > 1) ? $clog2(POOL_DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] CONV_W_A = ADDR_WIDTH'(CONV_RESULT_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_C_A = ADDR_WIDTH'(POOL_W - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_R_A = ADDR_WIDTH'(POOL_H - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);
  // One extra bit so a pooled map that fills the whole address space still
  // compares correctly.
  localparam logic [ADDR_WIDTH:0]   DEPTH_A  = (ADDR_WIDTH + 1)'(POOL_DEPTH);

  // Elaboration-time sanity checks on the parameter set. FRACTION_WIDTH only
  // documents the fixed-point format; max-pooling never rescales.
  generate
    if (POOL_DEPTH < 1 || FRACTION_WIDTH >= DATA_WIDTH ||
        PIDX_W > ADDR_WIDTH || POOL_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_params
      $error("pool_l1_relu_max: unsupported parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_row;
  logic [ADDR_WIDTH-1:0]   r_col;
  logic [1:0]              r_k;
  logic signed [DATA_WIDTH-1:0] r_acc;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_done;
  // Write pointer tracks row*POOL_W+col directly, so no multiplier is needed
  // on the write side.
  logic [PIDX_W-1:0]       r_wptr;
  logic [DATA_WIDTH-1:0]   r_pool_result;

  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   w_row_next;
  logic [ADDR_WIDTH-1:0]   w_col_next;
  logic [1:0]              w_k_next;
  logic signed [DATA_WIDTH-1:0] w_acc_next;
  logic [ADDR_WIDTH-1:0]   w_addr_next;
  logic                    w_done_next;
  logic [PIDX_W-1:0]       w_wptr_next;
  logic                    w_wr_en;

  logic signed [DATA_WIDTH-1:0] w_word;
  logic signed [DATA_WIDTH-1:0] w_acc_max;
  logic [PIDX_W-1:0]       w_rd_idx;
  logic                    w_rd_in_range;

  // Pooled map storage: one write port (FSM) and one registered read port.
  logic [DATA_WIDTH-1:0]   r_mem [POOL_DEPTH];

  // ---------------------------------------------------------------------------
  // Window address: (2*row + dr) * CONV_RESULT_WIDTH + (2*col + dc), where the
  // fetch index k encodes the offset as {dr, dc}: (0,0),(0,1),(1,0),(1,1).
  // ---------------------------------------------------------------------------
  function automatic logic [ADDR_WIDTH-1:0] win_addr(
    input logic [ADDR_WIDTH-1:0] row,
    input logic [ADDR_WIDTH-1:0] col,
    input logic [1:0]            k
  );
    logic [ADDR_WIDTH-1:0] y;
    logic [ADDR_WIDTH-1:0] x;
    y = (row << 1) | {{(ADDR_WIDTH-1){1'b0}}, k[1]};
    x = (col << 1) | {{(ADDR_WIDTH-1){1'b0}}, k[0]};
    return y * CONV_W_A + x;
  endfunction

  // Signed running max. The accumulator starts at 0 for every window, which
  // folds the ReLU into the max.
  assign w_word    = conv_result;
  assign w_acc_max = (w_word > r_acc) ? w_word : r_acc;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_row_next   = r_row;
    w_col_next   = r_col;
    w_k_next     = r_k;
    w_acc_next   = r_acc;
    w_addr_next  = r_addr;
    w_done_next  = r_done;
    w_wptr_next  = r_wptr;
    w_wr_en      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_done_next = 1'b0;
        if (run) begin
          w_state_next = S_FETCH;
          w_row_next   = '0;
          w_col_next   = '0;
          w_k_next     = 2'd0;
          w_acc_next   = '0;
          w_wptr_next  = '0;
          w_addr_next  = '0;  // window (0,0), offset (0,0)
        end
      end

      S_FETCH: begin
        // The word arriving now belongs to the address presented last cycle;
        // in k=0 the bus still carries data from an earlier window.
        if (r_k != 2'd0) begin
          w_acc_next = w_acc_max;
        end
        if (r_k == 2'd3) begin
          w_state_next = S_DRAIN;  // address held; 4th word arrives next cycle
        end else begin
          w_k_next    = r_k + 2'd1;
          w_addr_next = win_addr(r_row, r_col, w_k_next);
        end
      end

      S_DRAIN: begin
        w_acc_next   = w_acc_max;
        w_state_next = S_WRITE;
      end

      S_WRITE: begin
        w_wr_en     = 1'b1;
        w_wptr_next = r_wptr + PIDX_W'(1);
        if (r_row == LAST_R_A && r_col == LAST_C_A) begin
          w_state_next = S_DONE;
          w_done_next  = 1'b1;
        end else begin
          if (r_col == LAST_C_A) begin
            w_col_next = '0;
            w_row_next = r_row + ONE_A;
          end else begin
            w_col_next = r_col + ONE_A;
          end
          w_state_next = S_FETCH;
          w_k_next     = 2'd0;
          w_acc_next   = '0;
          w_addr_next  = win_addr(w_row_next, w_col_next, 2'd0);
        end
      end

      S_DONE: begin
        w_done_next = 1'b1;
        if (!run) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b0;
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_done_next  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_k     <= 2'd0;
      r_acc   <= '0;
      r_addr  <= '0;
      r_done  <= 1'b0;
      r_wptr  <= '0;
    end else begin
      r_state <= w_state_next;
      r_row   <= w_row_next;
      r_col   <= w_col_next;
      r_k     <= w_k_next;
      r_acc   <= w_acc_next;
      r_addr  <= w_addr_next;
      r_done  <= w_done_next;
      r_wptr  <= w_wptr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Pooled buffer. Contents survive reset; a write coinciding with reset is
  // suppressed so an aborted run never commits a half-built window.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_en && !reset) begin
      r_mem[r_wptr] <= r_acc;
    end
  end

  // Registered read: a same-cycle write to the same address returns old data.
  assign w_rd_idx      = pool_read_address[PIDX_W-1:0];
  assign w_rd_in_range = ({1'b0, pool_read_address} < DEPTH_A);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pool_result <= '0;
    end else if (w_rd_in_range) begin
      r_pool_result <= r_mem[w_rd_idx];
    end else begin
      r_pool_result <= '0;
    end
  end

  assign conv_result_addr = r_addr;
  assign done             = r_done;
  assign pool_result      = r_pool_result;

endmodule

// File: tb/tb_pool_l1_relu_max.sv
// -----------------------------------------------------------------------------
// tb_pool_l1_relu_max
//
// Two instances share clock and reset: a default 24x24 map (dut_a) and an odd
// 5x5 map (dut_b). Each has a one-cycle-latency conv result memory model.
// Pool-buffer reads push the expected word into a scoreboard queue, and an
// independent monitor pops and compares when a read result is due.
// -----------------------------------------------------------------------------
module tb_pool_l1_relu_max;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        run_a, run_b;
  logic [9:0]  conv_addr_a, conv_addr_b;
  logic [15:0] conv_a, conv_b;
  logic [9:0]  pool_addr_a, pool_addr_b;
  logic [15:0] pool_a, pool_b;
  logic        done_a, done_b;

  pool_l1_relu_max dut_a (
    .clk               (clk),
    .reset             (reset),
    .run               (run_a),
    .conv_result_addr  (conv_addr_a),
    .conv_result       (conv_a),
    .pool_read_address (pool_addr_a),
    .pool_result       (pool_a),
    .done              (done_a)
  );

  pool_l1_relu_max #(
    .CONV_RESULT_WIDTH  (5),
    .CONV_RESULT_HEIGHT (5)
  ) dut_b (
    .clk               (clk),
    .reset             (reset),
    .run               (run_b),
    .conv_result_addr  (conv_addr_b),
    .conv_result       (conv_b),
    .pool_read_address (pool_addr_b),
    .pool_result       (pool_b),
    .done              (done_b)
  );

  // Conv result memories: data valid one cycle after the address.
  logic [15:0] map_a [576];
  logic [15:0] map_b [25];

  always @(posedge clk) begin
    conv_a <= (conv_addr_a < 10'd576) ? map_a[conv_addr_a] : 16'h0000;
    conv_b <= (conv_addr_b < 10'd25)  ? map_b[conv_addr_b] : 16'h0000;
  end

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // Scoreboard for pool-buffer reads
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        which;
    logic [9:0]  addr;
    logic [15:0] exp;
  } rd_t;

  rd_t         exp_q[$];
  logic        rd_req_a = 1'b0, rd_req_b = 1'b0;
  logic        rd_vld_a = 1'b0, rd_vld_b = 1'b0;
  rd_t         mon_it;
  logic [15:0] mon_act;

  always @(posedge clk) begin
    rd_vld_a <= rd_req_a;
    rd_vld_b <= rd_req_b;
  end

  always @(negedge clk) begin
    if (rd_vld_a || rd_vld_b) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pool_rd: read data with empty scoreboard got=%h want=none",
                 rd_vld_b ? pool_b : pool_a);
      end else begin
        mon_it  = exp_q.pop_front();
        mon_act = mon_it.which ? pool_b : pool_a;
        if (mon_act !== mon_it.exp) begin
          bad++;
          $display("FAIL pool_rd dut=%0d addr=%0d got=%h want=%h",
                   mon_it.which, mon_it.addr, mon_act, mon_it.exp);
        end else begin
          $display("pool_rd dut=%0d addr=%0d data=%h ok",
                   mon_it.which, mon_it.addr, mon_act);
        end
      end
    end
  end

  // Watch for conv addresses on the 5x5 instance that must never be driven.
  logic mon_b = 1'b0;
  int   bad_addr_cnt = 0;
  always @(negedge clk) begin
    if (mon_b && (conv_addr_b == 10'd4 || conv_addr_b == 10'd9 ||
                  conv_addr_b == 10'd14 || conv_addr_b == 10'd19 ||
                  conv_addr_b >= 10'd20)) begin
      bad_addr_cnt++;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end else begin
      $display("check %s: %0d ok", name, act);
    end
  endtask

  task automatic pool_read(input bit which, input int addr, input logic [15:0] exp);
    rd_t it;
    @(negedge clk);
    it.which = which;
    it.addr  = 10'(addr);
    it.exp   = exp;
    exp_q.push_back(it);
    if (which) begin
      pool_addr_b = 10'(addr);
      rd_req_b    = 1'b1;
      rd_req_a    = 1'b0;
    end else begin
      pool_addr_a = 10'(addr);
      rd_req_a    = 1'b1;
      rd_req_b    = 1'b0;
    end
  endtask

  task automatic pool_read_end();
    @(negedge clk);
    rd_req_a = 1'b0;
    rd_req_b = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  int addr_seq[4];

  // Raise run, then count edges after the run-sampling edge until done reads 1.
  task automatic do_run(input bit which, input int exp_cyc, input bit chk_addr, input string tag);
    int cyc;
    @(negedge clk);
    if (which) run_b = 1'b1; else run_a = 1'b1;
    @(posedge clk);  // run sampled here (t0)
    cyc = 0;
    forever begin
      @(negedge clk);
      if (chk_addr && cyc < 4) begin
        check($sformatf("%s_fetch_addr%0d", tag, cyc), int'(conv_addr_a), addr_seq[cyc]);
      end
      if (which ? done_b : done_a) break;
      if (cyc > 5000) begin
        bad++;
        total++;
        $display("FAIL %s_done_timeout: got=no_done want=done by %0d", tag, exp_cyc);
        break;
      end
      @(posedge clk);
      cyc++;
    end
    check($sformatf("%s_done_latency", tag), cyc, exp_cyc);
  endtask

  task automatic drop_run(input bit which, input string tag);
    @(negedge clk);
    if (which) run_b = 1'b0; else run_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s_done_fall", tag), int'(which ? done_b : done_a), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int snap;
    reset       = 1'b1;
    run_a       = 1'b0;
    run_b       = 1'b0;
    pool_addr_a = '0;
    pool_addr_b = '0;
    addr_seq[0] = 0;
    addr_seq[1] = 1;
    addr_seq[2] = 24;
    addr_seq[3] = 25;

    // Ramp map with the mixed window planted at pool (0,0).
    for (int i = 0; i < 576; i++) map_a[i] = 16'(i);
    map_a[0]  = 16'hFFFD;  // -3
    map_a[1]  = 16'h0007;  //  7
    map_a[24] = 16'h7FFF;  // max positive
    map_a[25] = 16'h8000;  // -32768
    for (int i = 0; i < 25; i++) map_b[i] = 16'(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done_a", int'(done_a), 0);
    check("rst_conv_addr_a", int'(conv_addr_a), 0);
    check("rst_pool_result_a", int'(pool_a), 0);
    check("rst_done_b", int'(done_b), 0);
    reset = 1'b0;

    // Ramp + mixed window run: fetch order 0,1,24,25 and 864-cycle latency.
    do_run(0, 864, 1, "ramp");

    // Hold run high: done stays, no second pass (address parked on 575).
    repeat (20) @(negedge clk);
    check("hold_done", int'(done_a), 1);
    check("hold_no_rerun_addr", int'(conv_addr_a), 575);
    drop_run(0, "ramp");

    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 12; c++) begin
        pool_read(0, r * 12 + c,
                  (r == 0 && c == 0) ? 16'h7FFF : 16'((2 * r + 1) * 24 + 2 * c + 1));
      end
    end
    pool_read(0, 143, 16'd575);
    pool_read(0, 144, 16'h0000);
    pool_read(0, 1023, 16'h0000);
    pool_read_end();

    // Negative map, aborted by reset at cycle 100, then a fresh full run.
    for (int i = 0; i < 576; i++) map_a[i] = 16'hFFFB;
    @(negedge clk);
    run_a = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    snap = int'(conv_addr_a);
    check("midrun_addr_nonzero", int'(snap != 0), 1);
    reset = 1'b1;
    run_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrun_rst_done", int'(done_a), 0);
    check("midrun_rst_addr", int'(conv_addr_a), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("after_rst_idle_addr", int'(conv_addr_a), 0);
    check("after_rst_idle_done", int'(done_a), 0);

    do_run(0, 864, 0, "neg");
    drop_run(0, "neg");
    for (int i = 0; i < 144; i++) pool_read(0, i, 16'h0000);
    pool_read_end();

    // Odd 5x5 map: four windows, trailing row/column never fetched.
    snap  = bad_addr_cnt;
    mon_b = 1'b1;
    do_run(1, 24, 0, "odd5");
    mon_b = 1'b0;
    check("odd5_forbidden_addr_hits", bad_addr_cnt - snap, 0);
    drop_run(1, "odd5");
    pool_read(1, 0, 16'd6);
    pool_read(1, 1, 16'd8);
    pool_read(1, 2, 16'd16);
    pool_read(1, 3, 16'd18);
    pool_read(1, 4, 16'h0000);
    pool_read_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
